// File: rtl/axis_icrc_check.sv
// -----------------------------------------------------------------------------
// axis_icrc_check
//
// Receive-side RoCEv2 ICRC checker. It sits after the field-masking stage and
// has two inputs for the same beat:
//   - the masked stream, which feeds the CRC-32, and
//   - the original (not masked) data, which is what gets forwarded.
// The 4-byte ICRC trailer is stripped from the forwarded frame. A bad or runt
// frame is flagged on tuser[0] of its last output beat. Each frame also gives
// a one-cycle icrc_ok or icrc_bad pulse.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   s_axis_masked_*           masked input stream (tdata/tkeep/tvalid/tready/
//                             tlast/tuser); tkeep is contiguous from lane 0
//   s_axis_not_masked_tdata   original data, aligned with the masked beat
//   m_axis_*                  output stream with the ICRC removed
//                             (tuser[0] = upstream bad OR icrc bad, last beat)
//   icrc_ok / icrc_bad        per-frame status strobes, asserted in the cycle
//                             the tlast beat is accepted
//
// Datapath: hold register H feeds output register O.
// A non-last beat stays in H until the next beat of the frame arrives. This
// matters when the trailer is split: if the last input beat carries four or
// fewer bytes, the beat held in H can still be trimmed and turned into the
// last beat.
// -----------------------------------------------------------------------------
module axis_icrc_check #(
    parameter int DATA_WIDTH = 64,
    parameter int USER_WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   s_axis_masked_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_masked_tkeep,
    input  logic                    s_axis_masked_tvalid,
    output logic                    s_axis_masked_tready,
    input  logic                    s_axis_masked_tlast,
    input  logic [USER_WIDTH-1:0]   s_axis_masked_tuser,
    input  logic [DATA_WIDTH-1:0]   s_axis_not_masked_tdata,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    icrc_ok,
    output logic                    icrc_bad
);

    localparam int          KW           = DATA_WIDTH / 8;
    localparam logic [31:0] CRC_POLY_REF = 32'hEDB88320;
    localparam logic [31:0] CRC_RESIDUE  = 32'hDEBB20E3;

    // One byte of reflected CRC-32, LSB of the byte first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data_in);
        logic [31:0] c;
        c = crc_in ^ {24'd0, data_in};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY_REF) : (c >> 1);
        end
        return c;
    endfunction

    // Register state after the all-ones init plus the 8-byte 0xFF dummy LRH
    // that RoCEv2 prepends to the ICRC coverage.
    function automatic logic [31:0] calc_seed();
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) begin
            c = crc_byte(c, 8'hFF);
        end
        return c;
    endfunction

    localparam logic [31:0] ICRC_SEED = calc_seed();

    // State
    logic                  h_valid_q, h_valid_d;
    logic [DATA_WIDTH-1:0] h_data_q,  h_data_d;
    logic [KW-1:0]         h_keep_q,  h_keep_d;
    logic                  h_last_q,  h_last_d;
    logic [USER_WIDTH-1:0] h_user_q,  h_user_d;
    logic                  o_valid_q, o_valid_d;
    logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
    logic [KW-1:0]         o_keep_q,  o_keep_d;
    logic                  o_last_q,  o_last_d;
    logic [USER_WIDTH-1:0] o_user_q,  o_user_d;
    logic [31:0]           crc_q,     crc_d;
    logic                  sof_q,     sof_d;
    logic [USER_WIDTH-1:0] user_first_q, user_first_d;

    // Per-beat decode
    logic                  o_free;
    logic                  s_fire;
    logic                  h_move;
    logic [7:0]            k_cnt;
    logic [2:0]            trim_sh;
    logic [31:0]           crc_next;
    logic                  is_runt;
    logic                  frame_bad;
    logic                  beat_last;
    logic                  drop_beat;
    logic [USER_WIDTH-1:0] user_base;

    always_comb begin
        o_free               = !o_valid_q || m_axis_tready;
        s_axis_masked_tready = !rst && (!h_valid_q || o_free);
        s_fire               = s_axis_masked_tvalid && s_axis_masked_tready;

        // tkeep is contiguous, so a population count gives the byte count.
        k_cnt = 8'd0;
        for (int i = 0; i < KW; i++) begin
            k_cnt = k_cnt + {7'd0, s_axis_masked_tkeep[i]};
        end
        trim_sh = 3'(8'd4 - k_cnt);

        crc_next = crc_q;
        for (int i = 0; i < KW; i++) begin
            if (s_axis_masked_tkeep[i]) begin
                crc_next = crc_byte(crc_next, s_axis_masked_tdata[8*i +: 8]);
            end
        end

        // A frame of four bytes or fewer has no payload to check against.
        // The same is true of an empty tlast beat.
        is_runt   = (k_cnt == 8'd0) || (sof_q && (k_cnt <= 8'd4));
        frame_bad = is_runt || (crc_next != CRC_RESIDUE);
        beat_last = s_fire && s_axis_masked_tlast;
        // The trailer ends inside this beat and the beat holds nothing else.
        // Drop the beat and close the frame on the beat held in H.
        drop_beat = beat_last && !is_runt && (k_cnt <= 8'd4);

        // A non-last H beat leaves only when its successor arrives.
        h_move    = h_valid_q && o_free && (h_last_q || s_fire);
        user_base = sof_q ? s_axis_masked_tuser : user_first_q;

        icrc_ok  = beat_last && !frame_bad;
        icrc_bad = beat_last && frame_bad;

        crc_d        = crc_q;
        sof_d        = sof_q;
        user_first_d = user_first_q;
        if (s_fire) begin
            crc_d = s_axis_masked_tlast ? ICRC_SEED : crc_next;
            sof_d = s_axis_masked_tlast;
            if (sof_q) begin
                user_first_d = s_axis_masked_tuser;
            end
        end

        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_keep_d  = o_keep_q;
        o_last_d  = o_last_q;
        o_user_d  = o_user_q;
        if (h_move) begin
            o_valid_d = 1'b1;
            o_data_d  = h_data_q;
            o_keep_d  = h_keep_q;
            o_last_d  = h_last_q;
            o_user_d  = h_user_q;
            if (drop_beat) begin
                o_keep_d    = h_keep_q >> trim_sh;
                o_last_d    = 1'b1;
                o_user_d[0] = s_axis_masked_tuser[0] | frame_bad;
            end
        end else if (m_axis_tready) begin
            o_valid_d = 1'b0;
        end

        h_valid_d = h_valid_q;
        h_data_d  = h_data_q;
        h_keep_d  = h_keep_q;
        h_last_d  = h_last_q;
        h_user_d  = h_user_q;
        if (s_fire && !drop_beat) begin
            h_valid_d = 1'b1;
            h_data_d  = s_axis_not_masked_tdata;
            h_last_d  = s_axis_masked_tlast;
            // Keep is contiguous from lane 0, so shifting right by four
            // removes the four highest valid lanes, which hold the trailer.
            h_keep_d  = (s_axis_masked_tlast && !is_runt) ?
                        (s_axis_masked_tkeep >> 4) : s_axis_masked_tkeep;
            h_user_d    = user_base;
            h_user_d[0] = s_axis_masked_tlast ?
                          (s_axis_masked_tuser[0] | frame_bad) : 1'b0;
        end else if (h_move) begin
            h_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        h_data_q     <= h_data_d;
        h_keep_q     <= h_keep_d;
        h_last_q     <= h_last_d;
        h_user_q     <= h_user_d;
        o_data_q     <= o_data_d;
        o_keep_q     <= o_keep_d;
        o_last_q     <= o_last_d;
        o_user_q     <= o_user_d;
        user_first_q <= user_first_d;
        if (rst) begin
            h_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
            crc_q     <= ICRC_SEED;
            sof_q     <= 1'b1;
        end else begin
            h_valid_q <= h_valid_d;
            o_valid_q <= o_valid_d;
            crc_q     <= crc_d;
            sof_q     <= sof_d;
        end
    end

    assign m_axis_tdata  = o_data_q;
    assign m_axis_tkeep  = o_keep_q;
    assign m_axis_tvalid = o_valid_q;
    assign m_axis_tlast  = o_last_q;
    assign m_axis_tuser  = o_user_q;

endmodule

// File: tb/tb_axis_icrc_check.sv
// -----------------------------------------------------------------------------
// tb_axis_icrc_check
//
// Each frame is built as a random masked payload plus a differently
// randomised unmasked payload. The ICRC is computed with a table-driven
// reference CRC and appended in FCS byte order. The expected output beats
// (unmasked payload, trailer removed) are pushed to a scoreboard when the
// frame is driven. A monitor pops and compares them as the DUT emits beats.
// -----------------------------------------------------------------------------
module tb_axis_icrc_check;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk;
    logic          rst;
    logic [DW-1:0] s_mdata;
    logic [KW-1:0] s_keep;
    logic          s_valid;
    logic          s_ready;
    logic          s_last;
    logic [0:0]    s_user;
    logic [DW-1:0] s_udata;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [0:0]    m_tuser;
    logic          icrc_ok;
    logic          icrc_bad;

    axis_icrc_check #(.DATA_WIDTH(DW), .USER_WIDTH(1)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .s_axis_masked_tdata     (s_mdata),
        .s_axis_masked_tkeep     (s_keep),
        .s_axis_masked_tvalid    (s_valid),
        .s_axis_masked_tready    (s_ready),
        .s_axis_masked_tlast     (s_last),
        .s_axis_masked_tuser     (s_user),
        .s_axis_not_masked_tdata (s_udata),
        .m_axis_tdata            (m_tdata),
        .m_axis_tkeep            (m_tkeep),
        .m_axis_tvalid           (m_tvalid),
        .m_axis_tready           (m_tready),
        .m_axis_tlast            (m_tlast),
        .m_axis_tuser            (m_tuser),
        .icrc_ok                 (icrc_ok),
        .icrc_bad                (icrc_bad)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          user0;
    } beat_t;

    beat_t       sb[$];
    logic [7:0]  frame_m[$];
    logic [7:0]  frame_u[$];
    logic [31:0] crc_tab[256];
    logic [31:0] seed;

    int tests_run    = 0;
    int tests_failed = 0;
    int out_beats    = 0;
    int ok_cnt       = 0;
    int bad_cnt      = 0;
    int stall_cnt    = 0;
    int tready_mode  = 1;   // 0: low, 1: high, 2: random 50%

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        m_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (tready_mode)
                0:       m_tready = 1'b0;
                1:       m_tready = 1'b1;
                default: m_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Output monitor: scoreboard pop and compare, status pulse counting.
    initial begin
        beat_t       e;
        logic [DW-1:0] mask;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (icrc_ok)  ok_cnt++;
                if (icrc_bad) bad_cnt++;
                if (m_tvalid && m_tready) begin
                    out_beats++;
                    tests_run++;
                    if (sb.size() == 0) begin
                        tests_failed++;
                        $display("FAIL out_beat: unexpected beat data=%h keep=%h last=%b, required no beat",
                                 m_tdata, m_tkeep, m_tlast);
                    end else begin
                        e = sb.pop_front();
                        for (int j = 0; j < KW; j++) mask[8*j +: 8] = {8{e.keep[j]}};
                        if ((m_tdata & mask) !== (e.data & mask) || m_tkeep !== e.keep ||
                            m_tlast !== e.last || m_tuser[0] !== e.user0) begin
                            tests_failed++;
                            $display("FAIL out_beat: got data=%h keep=%h last=%b user0=%b, required data=%h keep=%h last=%b user0=%b",
                                     m_tdata & mask, m_tkeep, m_tlast, m_tuser[0],
                                     e.data & mask, e.keep, e.last, e.user0);
                        end
                    end
                end
            end
        end
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        return (c >> 8) ^ crc_tab[c[7:0] ^ b];
    endfunction

    task automatic build_frame(input int plen, input bit corrupt);
        logic [31:0] c;
        logic [7:0]  m;
        int          idx;
        logic [7:0]  flip;
        frame_m.delete();
        frame_u.delete();
        c = seed;
        for (int i = 0; i < plen; i++) begin
            m = 8'($urandom);
            frame_m.push_back(m);
            frame_u.push_back(8'($urandom));
            c = crc_upd(c, m);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) begin
            frame_m.push_back(c[8*j +: 8]);
            frame_u.push_back(c[8*j +: 8]);
        end
        if (corrupt) begin
            idx  = $urandom_range(0, plen - 1);
            flip = 8'(1 << $urandom_range(0, 7));
            frame_m[idx] = frame_m[idx] ^ flip;
            frame_u[idx] = frame_u[idx] ^ flip;
        end
    endtask

    task automatic build_raw(input int n);
        frame_m.delete();
        frame_u.delete();
        for (int i = 0; i < n; i++) begin
            frame_m.push_back(8'($urandom));
            frame_u.push_back(8'($urandom));
        end
    endtask

    // Drives beat b of the current frame and waits for acceptance.
    // Entered and left at posedge+1.
    task automatic drive_beat(input int b, input bit up_bad, output logic f_ok, output logic f_bad);
        int            total;
        int            idx;
        int            wait_cnt;
        logic [DW-1:0] dm;
        logic [DW-1:0] du;
        logic [KW-1:0] kp;
        logic          lst;
        total = frame_m.size();
        for (int j = 0; j < KW; j++) begin
            idx = b * KW + j;
            if (idx < total) begin
                dm[8*j +: 8] = frame_m[idx];
                du[8*j +: 8] = frame_u[idx];
                kp[j] = 1'b1;
            end else begin
                dm[8*j +: 8] = 8'($urandom);
                du[8*j +: 8] = 8'($urandom);
                kp[j] = 1'b0;
            end
        end
        lst     = ((b + 1) * KW >= total);
        s_valid = 1'b1;
        s_mdata = dm;
        s_udata = du;
        s_keep  = kp;
        s_last  = lst;
        s_user  = 1'(lst && up_bad);
        wait_cnt = 0;
        @(negedge clk);
        while (!s_ready && wait_cnt < 1000) begin
            wait_cnt++;
            @(negedge clk);
        end
        stall_cnt += wait_cnt;
        if (!s_ready) begin
            tests_run++;
            tests_failed++;
            $display("FAIL accept_timeout: beat %0d tready=%b, required 1 within 1000 cycles", b, s_ready);
        end
        f_ok  = icrc_ok;
        f_bad = icrc_bad;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit up_bad, input bit exp_bad, input bit chk_status);
        int    total;
        int    nb;
        int    plen;
        int    onb;
        int    idx;
        beat_t e;
        logic  f_ok;
        logic  f_bad;
        total = frame_m.size();
        nb    = (total + KW - 1) / KW;
        if (total <= 4) begin
            e = '0;
            for (int j = 0; j < total; j++) begin
                e.data[8*j +: 8] = frame_u[j];
                e.keep[j] = 1'b1;
            end
            e.last  = 1'b1;
            e.user0 = 1'b1;
            sb.push_back(e);
        end else begin
            plen = total - 4;
            onb  = (plen + KW - 1) / KW;
            for (int ob = 0; ob < onb; ob++) begin
                e = '0;
                for (int j = 0; j < KW; j++) begin
                    idx = ob * KW + j;
                    if (idx < plen) begin
                        e.data[8*j +: 8] = frame_u[idx];
                        e.keep[j] = 1'b1;
                    end
                end
                e.last  = (ob == onb - 1);
                e.user0 = e.last && (exp_bad || up_bad);
                sb.push_back(e);
            end
        end
        $display("[TB] frame bytes=%0d beats=%0d expect_bad=%0d upstream_bad=%0d", total, nb, exp_bad, up_bad);
        for (int b = 0; b < nb; b++) begin
            drive_beat(b, up_bad, f_ok, f_bad);
            if (b == nb - 1) begin
                if (chk_status) begin
                    tests_run++;
                    if (f_ok !== !exp_bad || f_bad !== exp_bad) begin
                        tests_failed++;
                        $display("FAIL status_last: icrc_ok=%b icrc_bad=%b, required ok=%b bad=%b",
                                 f_ok, f_bad, !exp_bad, exp_bad);
                    end
                end
            end else begin
                tests_run++;
                if (f_ok !== 1'b0 || f_bad !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL status_mid: icrc_ok=%b icrc_bad=%b on non-last beat, required 0 0", f_ok, f_bad);
                end
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int cnt;
        cnt     = 0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        @(negedge clk);
        while ((sb.size() != 0 || m_tvalid) && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
        tests_run++;
        if (sb.size() != 0 || m_tvalid) begin
            tests_failed++;
            $display("FAIL drain_%s: pending=%0d m_axis_tvalid=%b, required pending=0 tvalid=0",
                     name, sb.size(), m_tvalid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_counts(input string name, input int d_beats, input int d_ok, input int d_bad,
                                input int want_beats, input int want_ok, input int want_bad);
        tests_run++;
        if (d_beats !== want_beats || d_ok !== want_ok || d_bad !== want_bad) begin
            tests_failed++;
            $display("FAIL %s: beats=%0d ok=%0d bad=%0d, required beats=%0d ok=%0d bad=%0d",
                     name, d_beats, d_ok, d_bad, want_beats, want_ok, want_bad);
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_keep  = '0;
        s_user  = '0;
        s_mdata = '0;
        s_udata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m_tvalid !== 1'b0 || s_ready !== 1'b0 || icrc_ok !== 1'b0 || icrc_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: tvalid=%b tready=%b ok=%b bad=%b, required 0 0 0 0",
                     m_tvalid, s_ready, icrc_ok, icrc_bad);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (s_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: tready=%b, required 1", s_ready);
        end
        @(posedge clk);
        #1;
    endtask

    // Runs one good (or deliberately corrupted) frame and checks beat/status counts.
    task automatic run_single(input string name, input int plen, input bit corrupt, input int want_beats);
        int b0;
        int k0;
        int x0;
        b0 = out_beats;
        k0 = ok_cnt;
        x0 = bad_cnt;
        build_frame(plen, corrupt);
        send_frame(1'b0, corrupt, 1'b1);
        wait_drain(name);
        check_counts(name, out_beats - b0, ok_cnt - k0, bad_cnt - x0,
                     want_beats, corrupt ? 0 : 1, corrupt ? 1 : 0);
    endtask

    task automatic test_good_3beat();  run_single("good_3beat", 20, 1'b0, 3); endtask
    task automatic test_keep_0f();     run_single("keep_0f",    16, 1'b0, 2); endtask
    task automatic test_keep_03();     run_single("keep_03",    14, 1'b0, 2); endtask
    task automatic test_bad_icrc();    run_single("bad_icrc",   14, 1'b1, 2); endtask

    task automatic test_upstream_bad();
        build_frame(11, 1'b0);
        send_frame(1'b1, 1'b0, 1'b0);
        wait_drain("upstream_bad");
    endtask

    task automatic test_random_frames();
        int k0;
        int x0;
        bit cor;
        int n_bad;
        k0 = ok_cnt;
        x0 = bad_cnt;
        n_bad = 0;
        tready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            cor = ($urandom_range(0, 3) == 0);
            if (cor) n_bad++;
            build_frame($urandom_range(1, 60), cor);
            send_frame(1'b0, cor, 1'b1);
        end
        wait_drain("random_frames");
        tready_mode = 1;
        check_counts("random_frames_status", 0, ok_cnt - k0, bad_cnt - x0, 0, 20 - n_bad, n_bad);
    endtask

    task automatic test_back_to_back();
        int k0;
        tready_mode = 1;
        @(posedge clk);
        #1;
        k0 = ok_cnt;
        stall_cnt = 0;
        for (int f = 0; f < 10; f++) begin
            build_frame($urandom_range(1, 40), 1'b0);
            send_frame(1'b0, 1'b0, 1'b1);
        end
        wait_drain("back_to_back");
        check_counts("back_to_back_ok", 0, ok_cnt - k0, stall_cnt, 0, 10, 0);
    endtask

    task automatic test_runt_and_reset();
        int   b0;
        int   k0;
        int   x0;
        logic f_ok;
        logic f_bad;
        b0 = out_beats;
        k0 = ok_cnt;
        x0 = bad_cnt;
        build_raw(3);
        send_frame(1'b0, 1'b1, 1'b1);
        wait_drain("runt");
        check_counts("runt", out_beats - b0, ok_cnt - k0, bad_cnt - x0, 1, 0, 1);

        // Partial frame with the output stalled, then reset.
        tready_mode = 0;
        @(posedge clk);
        #1;
        k0 = ok_cnt;
        x0 = bad_cnt;
        build_frame(20, 1'b0);
        drive_beat(0, 1'b0, f_ok, f_bad);
        drive_beat(1, 1'b0, f_ok, f_bad);
        s_valid = 1'b0;
        @(negedge clk);
        tests_run++;
        if (m_tvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL midframe_pending: m_axis_tvalid=%b, required 1", m_tvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (m_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL midframe_reset: m_axis_tvalid=%b, required 0", m_tvalid);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tready_mode = 1;
        check_counts("midframe_no_status", 0, ok_cnt - k0, bad_cnt - x0, 0, 0, 0);
        run_single("after_reset", 21, 1'b0, 3);
    endtask

    initial begin
        logic [31:0] c;
        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            crc_tab[n] = c;
        end
        seed = 32'hFFFFFFFF;
        for (int i = 0; i < 8; i++) seed = crc_upd(seed, 8'hFF);

        test_reset();
        test_good_3beat();
        test_keep_0f();
        test_keep_03();
        test_bad_icrc();
        test_upstream_bad();
        test_random_frames();
        test_back_to_back();
        test_runt_and_reset();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
